// File: rtl/intc_ctrl.sv
// intc_ctrl: edge/level interrupt controller with a PEND/MASK/EDGE/CLR bus window, driving CP0 HWInt.
// Build option INTC_SYNC_EN: adds a 2-flop synchronizer on every src line (+2 cycles of latency).
module intc_ctrl #(
    parameter int          N_SRC     = 6,              // 1..6, width of hw_int
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F40   // 16-byte, word-aligned window
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic [31:0]      bus_addr,
    input  logic             bus_we,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic [N_SRC-1:0] hw_int,
    output logic             irq_valid,
    output logic [2:0]       irq_id
);

    typedef enum logic [1:0] {
        REG_PEND = 2'd0,
        REG_MASK = 2'd1,
        REG_EDGE = 2'd2,
        REG_CLR  = 2'd3
    } reg_sel_e;

    logic             in_win;
    reg_sel_e         reg_sel;
    logic             mask_we;
    logic             edge_we;
    logic [N_SRC-1:0] clr_bits;

    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] edge_q;
    logic [N_SRC-1:0] pend_next;

    // Byte-lane bits and the write-data bits above N_SRC carry no information here.
    logic unused_bits;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:N_SRC]};

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign in_win   = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel  = reg_sel_e'(bus_addr[3:2]);
    assign mask_we  = bus_we && in_win && (reg_sel == REG_MASK);
    assign edge_we  = bus_we && in_win && (reg_sel == REG_EDGE);
    assign clr_bits = (bus_we && in_win && (reg_sel == REG_CLR)) ? bus_wdata[N_SRC-1:0]
                                                                  : '0;

    // ------------------------------------------------------------------
    // Source conditioning
    // ------------------------------------------------------------------
`ifdef INTC_SYNC_EN
    logic [N_SRC-1:0] sync_q1;
    logic [N_SRC-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= src;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2;
`else
    assign s = src;
`endif

    // ------------------------------------------------------------------
    // Pending update: level bits follow s, edge bits latch rising edges.
    // A rising edge outranks a same-cycle CLR because the set term is ORed last.
    // ------------------------------------------------------------------
    assign pend_next = (edge_q & ((pend & ~clr_bits) | (s & ~src_q)))
                     | (~edge_q & s);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q  <= '0;
            pend   <= '0;
            mask   <= '0;
            edge_q <= '0;
        end else begin
            src_q <= s;
            pend  <= pend_next;
            if (mask_we) mask   <= bus_wdata[N_SRC-1:0];
            if (edge_we) edge_q <= bus_wdata[N_SRC-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Interrupt outputs, purely from registered pend/mask
    // ------------------------------------------------------------------
    assign hw_int    = pend & mask;
    assign irq_valid = |hw_int;

    // NOTE: default assignment first so the combinational block cannot infer a latch.
    always_comb begin
        irq_id = 3'd0;
        // Scan downward so the lowest-numbered active bit is the last one written.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (hw_int[i]) irq_id = 3'(i);
        end
    end

    // ------------------------------------------------------------------
    // Read mux: shows register state before any same-cycle write
    // ------------------------------------------------------------------
    always_comb begin
        bus_rdata = '0;
        if (in_win) begin
            case (reg_sel)
                REG_PEND: bus_rdata = {{(32 - N_SRC){1'b0}}, pend};
                REG_MASK: bus_rdata = {{(32 - N_SRC){1'b0}}, mask};
                REG_EDGE: bus_rdata = {{(32 - N_SRC){1'b0}}, edge_q};
                default:  bus_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_intc_ctrl.sv
// tb_intc_ctrl: table-driven bus vectors, directed latency/corner sequences and a randomized run
// against a per-source behavioural model of intc_ctrl (honours INTC_SYNC_EN latency).
module tb_intc_ctrl;

    localparam logic [31:0] B = 32'h0000_7F40;
`ifdef INTC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  src;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [5:0]  hw_int;
    logic        irq_valid;
    logic [2:0]  irq_id;

    int n_checks = 0;
    int n_errors = 0;

    intc_ctrl #(.N_SRC(6), .BASE_ADDR(B)) dut (
        .clk       (clk),
        .reset     (reset),
        .src       (src),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .hw_int    (hw_int),
        .irq_valid (irq_valid),
        .irq_id    (irq_id)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    bit         m_pend [6];
    bit         m_mask [6];
    bit         m_edge [6];
    bit         m_prev [6];
    logic [5:0] m_hist [$];   // src samples still travelling through the synchronizer

    function automatic int win_off(input logic [31:0] a);
        if (a >= B && a < B + 32'd16) return int'((a - B) / 32'd4);
        return -1;
    endfunction

    function automatic logic [5:0] pack(input bit v [6]);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [5:0] exp_hw();
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = m_pend[i] && m_mask[i];
        return r;
    endfunction

    function automatic logic [2:0] exp_id();
        logic [5:0] h;
        h = exp_hw();
        for (int i = 0; i < 6; i++) if (h[i]) return 3'(i);
        return 3'd0;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        case (win_off(a))
            0:       return {26'd0, pack(m_pend)};
            1:       return {26'd0, pack(m_mask)};
            2:       return {26'd0, pack(m_edge)};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_tick();
        logic [5:0] sv;
        int         off;
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                m_pend[i] = 0; m_mask[i] = 0; m_edge[i] = 0; m_prev[i] = 0;
            end
            m_hist.delete();
            for (int i = 0; i < LAT; i++) m_hist.push_back(6'd0);
            return;
        end
        if (LAT == 0) sv = src;
        else          sv = m_hist[0];
        off = bus_we ? win_off(bus_addr) : -1;
        for (int i = 0; i < 6; i++) begin
            if (m_edge[i]) begin
                if (sv[i] && !m_prev[i])            m_pend[i] = 1;
                else if (off == 3 && bus_wdata[i])  m_pend[i] = 0;
            end else begin
                m_pend[i] = sv[i];
            end
            m_prev[i] = sv[i];
            if (off == 1) m_mask[i] = bus_wdata[i];
            if (off == 2) m_edge[i] = bus_wdata[i];
        end
        if (LAT > 0) begin
            void'(m_hist.pop_front());
            m_hist.push_back(src);
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_hw_int"},    {26'd0, hw_int},   {26'd0, exp_hw()});
        check({tag, "_irq_valid"}, {31'd0, irq_valid}, {31'd0, |exp_hw()});
        check({tag, "_irq_id"},    {29'd0, irq_id},   {29'd0, exp_id()});
        check({tag, "_rdata"},     bus_rdata,         exp_rdata(bus_addr));
    endtask

    // One clock: model follows the inputs in force, then wait to the next sampling point.
    task automatic tick();
        model_tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [31:0] off, input logic [31:0] data);
        bus_we = 1'b1; bus_addr = B + off; bus_wdata = data;
        tick();
        bus_we = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] off, input logic [31:0] exp);
        bus_addr = B + off;
        #1;
        check(name, bus_rdata, exp);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [20];

    initial begin
        tbl = '{
            '{1'b0, B + 32'h04, 32'h0000_0000, 32'h00},
            '{1'b1, B + 32'h04, 32'hFFFF_FFFF, 32'h00},
            '{1'b0, B + 32'h04, 32'h0000_0000, 32'h3F},
            '{1'b1, B + 32'h08, 32'h0000_0015, 32'h00},
            '{1'b0, B + 32'h08, 32'h0000_0000, 32'h15},
            '{1'b1, B + 32'h10, 32'hFFFF_FFFF, 32'h00},
            '{1'b1, B + 32'h14, 32'h0000_0000, 32'h00},
            '{1'b1, B + 32'h18, 32'h0000_0000, 32'h00},
            '{1'b0, B + 32'h04, 32'h0000_0000, 32'h3F},
            '{1'b0, B + 32'h08, 32'h0000_0000, 32'h15},
            '{1'b1, B + 32'h00, 32'h0000_003F, 32'h00},
            '{1'b0, B + 32'h00, 32'h0000_0000, 32'h00},
            '{1'b0, B + 32'h0C, 32'h0000_0000, 32'h00},
            '{1'b1, B - 32'h04, 32'h0000_0000, 32'h00},
            '{1'b1, B + 32'h0C, 32'h0000_003F, 32'h00},
            '{1'b0, B + 32'h04, 32'h0000_0000, 32'h3F},
            '{1'b1, B + 32'h04, 32'h0000_000A, 32'h3F},
            '{1'b0, B + 32'h04, 32'h0000_0000, 32'h0A},
            '{1'b1, B + 32'h08, 32'h0000_0000, 32'h15},
            '{1'b0, B + 32'h08, 32'h0000_0000, 32'h00}
        };

        reset = 1'b1; src = 6'h3F; bus_we = 1'b0; bus_addr = B; bus_wdata = '0;

        // T1: reset held with all sources high
        repeat (3) tick();
        check("t1_hw_int", {26'd0, hw_int}, 32'd0);
        check("t1_irq_valid", {31'd0, irq_valid}, 32'd0);
        check("t1_irq_id", {29'd0, irq_id}, 32'd0);
        for (int k = 0; k < 4; k++) rd_check($sformatf("t1_rd_off%0d", 4 * k), 32'(4 * k), 32'd0);
        src = 6'h00;
        tick();
        reset = 1'b0;
        tick();

        // Table: bus decode, read-before-write, write masking
        for (int i = 0; i < 20; i++) begin
            bus_we = tbl[i].we; bus_addr = tbl[i].addr; bus_wdata = tbl[i].wdata;
            #1;
            check($sformatf("tbl%0d_rdata", i), bus_rdata, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_hw_int", i), {26'd0, hw_int}, 32'd0);
            tick();
            bus_we = 1'b0;
        end

        // T2: level source
        bus_wr(32'h4, 32'h3F);
        bus_wr(32'h8, 32'h00);
        src = 6'h04;
        #1;
        check("t2_no_comb_path", {26'd0, hw_int}, 32'd0);
        tick();
        repeat (LAT) begin
            check("t2_sync_delay", {26'd0, hw_int}, 32'd0);
            tick();
        end
        check("t2_hw_int", {26'd0, hw_int}, 32'h04);
        check("t2_irq_id", {29'd0, irq_id}, 32'd2);
        check("t2_irq_valid", {31'd0, irq_valid}, 32'd1);
        bus_wr(32'hC, 32'h04);
        check("t2_clr_on_level", {26'd0, hw_int}, 32'h04);
        src = 6'h00;
        tick();
        repeat (LAT) tick();
        check("t2_fall", {26'd0, hw_int}, 32'd0);

        // T3: edge source, CLR, and edge+CLR in the same cycle
        bus_wr(32'h8, 32'h01);
        bus_wr(32'h4, 32'h01);
        src = 6'h01;
        tick();
        src = 6'h00;
        repeat (LAT) tick();
        rd_check("t3_pend_set", 32'h0, 32'h01);
        repeat (3) tick();
        rd_check("t3_pend_held", 32'h0, 32'h01);
        check("t3_hw_int", {26'd0, hw_int}, 32'h01);
        check("t3_irq_id", {29'd0, irq_id}, 32'd0);
        bus_wr(32'hC, 32'h01);
        rd_check("t3_pend_cleared", 32'h0, 32'h00);
        check("t3_valid_cleared", {31'd0, irq_valid}, 32'd0);
        for (int i = 0; i <= LAT; i++) begin
            src = (i == 0) ? 6'h01 : 6'h00;
            if (i == LAT) begin
                bus_we = 1'b1; bus_addr = B + 32'hC; bus_wdata = 32'h01;
            end
            tick();
        end
        bus_we = 1'b0; src = 6'h00;
        rd_check("t3_set_beats_clr", 32'h0, 32'h01);
        bus_wr(32'hC, 32'h01);

        // T4: priority and mask
        bus_wr(32'h8, 32'h00);
        src = 6'h24;
        tick();
        repeat (LAT) tick();
        check("t4_premask", {26'd0, hw_int}, 32'd0);
        bus_wr(32'h4, 32'h3F);
        check("t4_irq_id_all", {29'd0, irq_id}, 32'd2);
        check("t4_hw_all", {26'd0, hw_int}, 32'h24);
        bus_wr(32'h4, 32'h20);
        check("t4_irq_id_hi", {29'd0, irq_id}, 32'd5);
        check("t4_hw_hi", {26'd0, hw_int}, 32'h20);
        bus_wr(32'h4, 32'h00);
        check("t4_valid_off", {31'd0, irq_valid}, 32'd0);
        check("t4_id_off", {29'd0, irq_id}, 32'd0);

        // T5: read PEND in the cycle a source rises returns the old value
        src = 6'h26;
        rd_check("t5_old_pend", 32'h0, 32'h24);
        tick();
        repeat (LAT) tick();
        rd_check("t5_new_pend", 32'h0, 32'h26);
        src = 6'h00;
        repeat (LAT + 1) tick();

        // T6: reset in the middle of an active edge interrupt
        bus_wr(32'h8, 32'h3F);
        bus_wr(32'h4, 32'h3F);
        src = 6'h08;
        repeat (LAT + 1) tick();
        check("t6_before_reset", {26'd0, hw_int}, 32'h08);
        reset = 1'b1;
        repeat (2) tick();
        rd_check("t6_pend_in_reset", 32'h0, 32'h00);
        src = 6'h00;
        reset = 1'b0;
        tick();
        rd_check("t6_pend_after", 32'h0, 32'h00);
        rd_check("t6_mask_after", 32'h4, 32'h00);
        check("t6_hw_after", {26'd0, hw_int}, 32'd0);

        // Randomized run against the model
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 2) == 0) src = src ^ 6'($urandom_range(0, 63));
            bus_we = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 9))
                0:       bus_addr = $urandom();
                1:       bus_addr = B + 32'($urandom_range(0, 23));
                default: bus_addr = B + 32'(4 * $urandom_range(0, 4));
            endcase
            bus_wdata = $urandom();
            #1;
            check_model($sformatf("rnd%0d", c));
            tick();
        end
        bus_we = 1'b0;
        reset  = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
